// File: rtl/hdmi_island_pkg.sv
// Shared types and timing constants for the HDMI data-island scheduler.
// Period lengths are in pixel-clock cycles.
package hdmi_island_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PREAMBLE    = 3'd1,
        ST_LEAD_GUARD  = 3'd2,
        ST_PACKET      = 3'd3,
        ST_TRAIL_GUARD = 3'd4
    } island_state_e;

    typedef enum logic [1:0] {
        PERIOD_IDLE     = 2'd0,
        PERIOD_PREAMBLE = 2'd1,
        PERIOD_GUARD    = 2'd2,
        PERIOD_PACKET   = 2'd3
    } period_e;

    localparam logic [1:0] SRC_AUDIO_SAMPLE = 2'd0;
    localparam logic [1:0] SRC_ACR          = 2'd1;
    localparam logic [1:0] SRC_AVI_IF       = 2'd2;
    localparam logic [1:0] SRC_AUDIO_IF     = 2'd3;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int VIDEO_LEAD   = 10;

    localparam logic [4:0] PREAMBLE_LAST = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] GUARD_LAST    = 5'(GUARD_LEN - 1);
    localparam logic [4:0] PACKET_LAST   = 5'(PACKET_LEN - 1);

    // From the start-check column: one cycle to the packet, the packet itself, then the trailing guard.
    localparam logic [10:0] START_SPAN = 11'(1 + PACKET_LEN + GUARD_LEN);

    function automatic period_e period_of(input island_state_e s);
        case (s)
            ST_PREAMBLE:                   return PERIOD_PREAMBLE;
            ST_LEAD_GUARD, ST_TRAIL_GUARD: return PERIOD_GUARD;
            ST_PACKET:                     return PERIOD_PACKET;
            default:                       return PERIOD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/island_arbiter.sv
// Fixed-priority packet source selector: bit 0 wins, bit 3 loses.
// Purely combinational; the scheduler samples it only at a packet start check.
module island_arbiter
    import hdmi_island_pkg::*;
(
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] winner,
    output logic       any_req
);

    always_comb begin
        grant   = 4'b0000;
        winner  = SRC_AUDIO_SAMPLE;
        any_req = |req;
        if (req[0]) begin
            grant  = 4'b0001;
            winner = SRC_AUDIO_SAMPLE;
        end else if (req[1]) begin
            grant  = 4'b0010;
            winner = SRC_ACR;
        end else if (req[2]) begin
            grant  = 4'b0100;
            winner = SRC_AVI_IF;
        end else if (req[3]) begin
            grant  = 4'b1000;
            winner = SRC_AUDIO_IF;
        end
    end

endmodule

// File: rtl/island_scheduler.sv
// Schedules one HDMI data island per line in horizontal blanking:
// preamble, leading guard, back-to-back packets while they fit, trailing guard.
module island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int WINDOW_START = 16,
    parameter int MAX_PACKETS  = 18
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] cx,
    input  logic [9:0] screen_start_x,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       island_active,
    output logic [1:0] period,
    output logic [1:0] pkt_sel,
    output logic [4:0] word_idx,
    output logic [2:0] state_dbg
);

    // req/gnt handshake: a source holds its req bit until it sees its gnt bit,
    // gnt is a one-cycle pulse in the first cycle of that source's packet, and
    // a bit withdrawn before then is simply never chosen.

    localparam logic [9:0] WINDOW_CX = 10'(WINDOW_START);
    localparam logic [5:0] MAX_PKTS  = 6'(MAX_PACKETS);

    island_state_e state_q, state_d;
    logic [4:0]    phase_q, phase_d;
    logic [4:0]    sent_q, sent_d;
    logic [1:0]    sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          active_q, active_d;
    logic [1:0]    period_q, period_d;
    logic [1:0]    pkt_sel_q, pkt_sel_d;
    logic [4:0]    word_q, word_d;

    logic [3:0]  arb_grant;
    logic [1:0]  arb_winner;
    logic        arb_any;
    logic [10:0] video_limit;
    logic [10:0] start_end;
    logic        start_ok;

    island_arbiter u_arbiter (
        .req     (req),
        .grant   (arb_grant),
        .winner  (arb_winner),
        .any_req (arb_any)
    );

    // The island must be fully closed before the video lead-in; clamp so a tiny screen_start_x cannot wrap.
    always_comb begin
        video_limit = (screen_start_x >= 10'(VIDEO_LEAD))
                    ? ({1'b0, screen_start_x} - 11'(VIDEO_LEAD)) : 11'd0;
        start_end   = {1'b0, cx} + START_SPAN;
        start_ok    = arb_any && ({1'b0, sent_q} < MAX_PKTS) && (start_end <= video_limit);
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            sent_q    <= '0;
            gnt_q     <= '0;
            active_q  <= 1'b0;
            period_q  <= '0;
            pkt_sel_q <= '0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            sent_q    <= sent_d;
            gnt_q     <= gnt_d;
            active_q  <= active_d;
            period_q  <= period_d;
            pkt_sel_q <= pkt_sel_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 5'd1;
        sent_d  = sent_q;
        sel_d   = pkt_sel_q;
        gnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                sent_d  = '0;
                if (cx == WINDOW_CX && arb_any) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (phase_q == PREAMBLE_LAST) begin
                    state_d = ST_LEAD_GUARD;
                    phase_d = '0;
                end
            end
            ST_LEAD_GUARD, ST_PACKET: begin
                if ((state_q == ST_LEAD_GUARD && phase_q == GUARD_LAST) ||
                    (state_q == ST_PACKET && phase_q == PACKET_LAST)) begin
                    phase_d = '0;
                    if (start_ok) begin
                        state_d = ST_PACKET;
                        sel_d   = arb_winner;
                        gnt_d   = arb_grant;
                        sent_d  = sent_q + 5'd1;
                    end else begin
                        state_d = ST_TRAIL_GUARD;
                    end
                end
            end
            ST_TRAIL_GUARD: begin
                if (phase_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_comb begin
        period_d  = period_of(state_d);
        active_d  = (state_d != ST_IDLE);
        pkt_sel_d = '0;
        word_d    = '0;
        if (state_d == ST_PACKET) begin
            pkt_sel_d = sel_d;
            word_d    = phase_d;
        end
    end

    assign gnt           = gnt_q;
    assign island_active = active_q;
    assign period        = period_q;
    assign pkt_sel       = pkt_sel_q;
    assign word_idx      = word_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_island_scheduler.sv
// Directed bench for island_scheduler: each task walks whole video lines
// and compares every output against hand-derived column timelines.
module tb_island_scheduler;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] cx;
    logic [9:0] screen_start_x;
    logic [3:0] req;

    logic [3:0] gnt;
    logic       island_active;
    logic [1:0] period;
    logic [1:0] pkt_sel;
    logic [4:0] word_idx;
    logic [2:0] state_dbg;

    logic [3:0] m2_gnt;
    logic       m2_island_active;
    logic [1:0] m2_period;
    logic [1:0] m2_pkt_sel;
    logic [4:0] m2_word_idx;
    logic [2:0] m2_state_dbg;

    int line_len;
    int compared;
    int mismatched;

    island_scheduler dut (
        .clk_pixel      (clk_pixel),
        .reset_n        (reset_n),
        .cx             (cx),
        .screen_start_x (screen_start_x),
        .req            (req),
        .gnt            (gnt),
        .island_active  (island_active),
        .period         (period),
        .pkt_sel        (pkt_sel),
        .word_idx       (word_idx),
        .state_dbg      (state_dbg)
    );

    island_scheduler #(.WINDOW_START(16), .MAX_PACKETS(2)) dut_m2 (
        .clk_pixel      (clk_pixel),
        .reset_n        (reset_n),
        .cx             (cx),
        .screen_start_x (screen_start_x),
        .req            (req),
        .gnt            (m2_gnt),
        .island_active  (m2_island_active),
        .period         (m2_period),
        .pkt_sel        (m2_pkt_sel),
        .word_idx       (m2_word_idx),
        .state_dbg      (m2_state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- expected timelines (WINDOW_START = 16, n packets) ----------------
    function automatic logic [1:0] exp_period(input int c, input int n);
        if (c >= 17 && c <= 24) return 2'd1;
        if (c == 25 || c == 26) return 2'd2;
        if (c >= 27 && c < 27 + 32 * n) return 2'd3;
        if (c >= 27 + 32 * n && c < 29 + 32 * n) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [4:0] exp_word(input int c, input int n);
        if (c >= 27 && c < 27 + 32 * n) return 5'((c - 27) % 32);
        return 5'd0;
    endfunction

    function automatic bit exp_slot(input int c, input int n);
        return (c >= 27 && c < 27 + 32 * n && (c - 27) % 32 == 0);
    endfunction

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk_pixel);
        #1;
        cx = (int'(cx) == line_len - 1) ? 10'd0 : cx + 10'd1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n        = 1'b0;
        cx             = 10'd0;
        req            = 4'b0000;
        screen_start_x = 10'd160;
        line_len       = 200;
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        compared++; if (island_active !== 1'b0) begin mismatched++; $display("FAIL reset_active got %b want 0", island_active); end
        compared++; if (period !== 2'd0) begin mismatched++; $display("FAIL reset_period got %0d want 0", period); end
        compared++; if (pkt_sel !== 2'd0) begin mismatched++; $display("FAIL reset_pkt_sel got %0d want 0", pkt_sel); end
        compared++; if (word_idx !== 5'd0) begin mismatched++; $display("FAIL reset_word_idx got %0d want 0", word_idx); end
        compared++; if (state_dbg !== 3'd0) begin mismatched++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        compared++; if (m2_island_active !== 1'b0) begin mismatched++; $display("FAIL reset_m2_active got %b want 0", m2_island_active); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_source();
        int c;
        int gcount;
        screen_start_x = 10'd160;
        line_len       = 200;
        req            = 4'b0001;
        for (int line = 0; line < 2; line++) begin
            gcount = 0;
            for (int i = 0; i < 200; i++) begin
                step();
                c = int'(cx);
                compared++; if (period !== exp_period(c, 3)) begin mismatched++; $display("FAIL single_period cx=%0d got %0d want %0d", c, period, exp_period(c, 3)); end
                compared++; if (island_active !== (exp_period(c, 3) != 2'd0)) begin mismatched++; $display("FAIL single_active cx=%0d got %b", c, island_active); end
                compared++; if (word_idx !== exp_word(c, 3)) begin mismatched++; $display("FAIL single_word cx=%0d got %0d want %0d", c, word_idx, exp_word(c, 3)); end
                compared++; if (gnt !== (exp_slot(c, 3) ? 4'b0001 : 4'b0000)) begin mismatched++; $display("FAIL single_gnt cx=%0d got %b", c, gnt); end
                compared++; if (pkt_sel !== 2'd0) begin mismatched++; $display("FAIL single_pkt_sel cx=%0d got %0d want 0", c, pkt_sel); end
                if (gnt[0]) gcount++;
            end
            compared++; if (gcount != 3) begin mismatched++; $display("FAIL single_gnt_count line=%0d got %0d want 3", line, gcount); end
        end
        req = 4'b0000;
    endtask

    task automatic test_all_requests();
        int c;
        int gcount;
        screen_start_x = 10'd160;
        line_len       = 200;
        req            = 4'b1111;
        gcount         = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            c = int'(cx);
            compared++; if (period !== exp_period(c, 3)) begin mismatched++; $display("FAIL prio_period cx=%0d got %0d want %0d", c, period, exp_period(c, 3)); end
            compared++; if (gnt !== (exp_slot(c, 3) ? 4'b0001 : 4'b0000)) begin mismatched++; $display("FAIL prio_gnt cx=%0d got %b", c, gnt); end
            compared++; if (pkt_sel !== 2'd0) begin mismatched++; $display("FAIL prio_pkt_sel cx=%0d got %0d want 0", c, pkt_sel); end
            if (gnt[0]) gcount++;
        end
        compared++; if (gcount != 3) begin mismatched++; $display("FAIL prio_gnt_count got %0d want 3", gcount); end
        req = 4'b0000;
    endtask

    task automatic test_drop_on_grant();
        int c;
        logic [3:0] want_gnt;
        logic [1:0] want_sel;
        screen_start_x = 10'd160;
        line_len       = 200;
        req            = 4'b1100;
        for (int i = 0; i < 200; i++) begin
            step();
            c = int'(cx);
            want_gnt = (c == 27) ? 4'b0100 : (c == 59) ? 4'b1000 : 4'b0000;
            want_sel = (exp_period(c, 2) != 2'd3) ? 2'd0 : (c < 59) ? 2'd2 : 2'd3;
            compared++; if (period !== exp_period(c, 2)) begin mismatched++; $display("FAIL drop_period cx=%0d got %0d want %0d", c, period, exp_period(c, 2)); end
            compared++; if (gnt !== want_gnt) begin mismatched++; $display("FAIL drop_gnt cx=%0d got %b want %b", c, gnt, want_gnt); end
            compared++; if (pkt_sel !== want_sel) begin mismatched++; $display("FAIL drop_pkt_sel cx=%0d got %0d want %0d", c, pkt_sel, want_sel); end
            compared++; if (word_idx !== exp_word(c, 2)) begin mismatched++; $display("FAIL drop_word cx=%0d got %0d want %0d", c, word_idx, exp_word(c, 2)); end
            if (gnt[2]) req[2] = 1'b0;
            if (gnt[3]) req[3] = 1'b0;
        end
        req = 4'b0000;
    endtask

    task automatic test_max_packets();
        int c;
        int g_def;
        int g_m2;
        screen_start_x = 10'd400;
        line_len       = 450;
        req            = 4'b0001;
        g_def          = 0;
        g_m2           = 0;
        for (int i = 0; i < 450; i++) begin
            step();
            c = int'(cx);
            compared++; if (m2_period !== exp_period(c, 2)) begin mismatched++; $display("FAIL max2_period cx=%0d got %0d want %0d", c, m2_period, exp_period(c, 2)); end
            compared++; if (m2_gnt !== (exp_slot(c, 2) ? 4'b0001 : 4'b0000)) begin mismatched++; $display("FAIL max2_gnt cx=%0d got %b", c, m2_gnt); end
            compared++; if (period !== exp_period(c, 11)) begin mismatched++; $display("FAIL wide_period cx=%0d got %0d want %0d", c, period, exp_period(c, 11)); end
            compared++; if (word_idx !== exp_word(c, 11)) begin mismatched++; $display("FAIL wide_word cx=%0d got %0d want %0d", c, word_idx, exp_word(c, 11)); end
            if (gnt[0]) g_def++;
            if (m2_gnt[0]) g_m2++;
        end
        compared++; if (g_m2 != 2) begin mismatched++; $display("FAIL max2_gnt_count got %0d want 2", g_m2); end
        compared++; if (g_def != 11) begin mismatched++; $display("FAIL wide_gnt_count got %0d want 11", g_def); end
        req = 4'b0000;
    endtask

    task automatic test_no_room_boundary();
        int c;
        int ssx_tab[3] = '{70, 71, 5};
        int n_tab[3]   = '{0, 1, 0};
        line_len = 200;
        req      = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            screen_start_x = 10'(ssx_tab[k]);
            for (int i = 0; i < 200; i++) begin
                step();
                c = int'(cx);
                compared++; if (period !== exp_period(c, n_tab[k])) begin mismatched++; $display("FAIL room_period ssx=%0d cx=%0d got %0d want %0d", ssx_tab[k], c, period, exp_period(c, n_tab[k])); end
                compared++; if (gnt !== (exp_slot(c, n_tab[k]) ? 4'b0001 : 4'b0000)) begin mismatched++; $display("FAIL room_gnt ssx=%0d cx=%0d got %b", ssx_tab[k], c, gnt); end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_preamble_drop();
        int c;
        screen_start_x = 10'd160;
        line_len       = 200;
        req            = 4'b0000;
        for (int i = 0; i < 200; i++) begin
            step();
            c = int'(cx);
            compared++; if (period !== exp_period(c, 0)) begin mismatched++; $display("FAIL pdrop_period cx=%0d got %0d want %0d", c, period, exp_period(c, 0)); end
            compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL pdrop_gnt cx=%0d got %b want 0000", c, gnt); end
            if (c == 16) req = 4'b0010;
            if (c == 20) req = 4'b0000;
        end
    endtask

    task automatic test_reset_mid_packet();
        int c;
        int gcount;
        screen_start_x = 10'd160;
        line_len       = 200;
        req            = 4'b0001;
        for (int i = 0; i < 40; i++) step();
        compared++; if (word_idx !== 5'd13) begin mismatched++; $display("FAIL midrst_pre_word got %0d want 13", word_idx); end
        compared++; if (period !== 2'd3) begin mismatched++; $display("FAIL midrst_pre_period got %0d want 3", period); end
        reset_n = 1'b0;
        #1;
        compared++; if (island_active !== 1'b0) begin mismatched++; $display("FAIL midrst_active got %b want 0", island_active); end
        compared++; if (period !== 2'd0) begin mismatched++; $display("FAIL midrst_period got %0d want 0", period); end
        compared++; if (word_idx !== 5'd0) begin mismatched++; $display("FAIL midrst_word got %0d want 0", word_idx); end
        compared++; if (pkt_sel !== 2'd0) begin mismatched++; $display("FAIL midrst_pkt_sel got %0d want 0", pkt_sel); end
        compared++; if (gnt !== 4'b0000) begin mismatched++; $display("FAIL midrst_gnt got %b want 0000", gnt); end
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 158; i++) begin
            step();
            c = int'(cx);
            compared++; if (period !== 2'd0 || island_active !== 1'b0) begin mismatched++; $display("FAIL midrst_quiet cx=%0d period=%0d active=%b want 0/0", c, period, island_active); end
        end
        gcount = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            c = int'(cx);
            compared++; if (period !== exp_period(c, 3)) begin mismatched++; $display("FAIL midrst_next_period cx=%0d got %0d want %0d", c, period, exp_period(c, 3)); end
            if (gnt[0]) gcount++;
        end
        compared++; if (gcount != 3) begin mismatched++; $display("FAIL midrst_gnt_count got %0d want 3", gcount); end
        req = 4'b0000;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single_source();
        test_all_requests();
        test_drop_on_grant();
        test_max_packets();
        test_no_room_boundary();
        test_preamble_drop();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
